alu16_sequencer: RTL and testbench

- Initiator-side controller for the existing 8-bit combinational `alu` (ports dataA, dataB, cs, carry_in → result, zero, carry_flag).
- Executes one 16-bit operation as two byte passes: low byte first, then high byte.
- For chaining opcodes, the low-pass carry feeds the high-pass carry_in.
- Sits between the calculator's operand/opcode registers and the `alu` instance; the `alu` is instantiated outside this block.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/alu.sv | 43 ++++
 rtl/alu16_sequencer.sv | 170 +++++++++++++++++
 tb/tb_alu16_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's 16-bit ALU sequencing.
// Optional build macro: ALU_WAIT_EN. It adds the LOW_W/HIGH_W hold states
// used with a registered-output alu.
package calc_pkg;

  // Sequencer states. The wait states exist only in the ALU_WAIT_EN build.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOW    = 3'd1,
    ST_HIGH   = 3'd2,
`ifdef ALU_WAIT_EN
    ST_FIN    = 3'd3,
    ST_LOW_W  = 3'd4,
    ST_HIGH_W = 3'd5
`else
    ST_FIN    = 3'd3
`endif
  } seq_state_e;

  // Add-with-carry opcode of the 8-bit alu.
  localparam logic [2:0] CS_ADC = 3'b011;

  // By default, only add-with-carry chains the low-byte carry upward.
  localparam logic [7:0] CHAIN_MASK_DEFAULT = 8'b0000_1000;

endpackage

// File: rtl/alu.sv
// 8-bit combinational alu used by the calculator.
// Opcodes:
//   000 add
//   001 subtract
//   010 and
//   011 add with carry
//   100 or
//   101 xor
//   110 not A
//   111 pass B
// carry_flag is bit 8 of the 9-bit result. zero flags an all-zero result.
module alu (
  input  logic [7:0] dataA,
  input  logic [7:0] dataB,
  input  logic [2:0] cs,
  input  logic       carry_in,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry_flag
);

  logic [8:0] wide_s;

  // Opcode decode into a 9-bit result; bit 8 becomes the carry flag.
  always_comb begin
    wide_s = 9'd0;
    case (cs)
      3'b000:  wide_s = {1'b0, dataA} + {1'b0, dataB};
      3'b001:  wide_s = {1'b0, dataA} - {1'b0, dataB};
      3'b010:  wide_s = {1'b0, dataA & dataB};
      3'b011:  wide_s = {1'b0, dataA} + {1'b0, dataB} + {8'd0, carry_in};
      3'b100:  wide_s = {1'b0, dataA | dataB};
      3'b101:  wide_s = {1'b0, dataA ^ dataB};
      3'b110:  wide_s = {1'b0, ~dataA};
      default: wide_s = {1'b0, dataB};
    endcase
  end

  assign result     = wide_s[7:0];
  assign zero       = (wide_s[7:0] == 8'd0);
  assign carry_flag = wide_s[8];

endmodule

// File: rtl/alu16_sequencer.sv
// Runs one 16-bit operation through the external 8-bit alu in two byte
// passes: the low byte first, then the high byte. For chaining opcodes
// (CHAIN_MASK), the carry from the low pass feeds the high pass.
// Optional build macro: ALU_WAIT_EN. Each pass holds the alu inputs for two
// cycles, and the response is sampled on the second cycle.
// All outputs, including the alu_* drive, are registered.
module alu16_sequencer
  import calc_pkg::*;
#(
  parameter logic [7:0] CHAIN_MASK = CHAIN_MASK_DEFAULT,
  parameter int         BYTE_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [2:0]  op_cs,
  input  logic        op_cin,
  output logic [7:0]  alu_dataA,
  output logic [7:0]  alu_dataB,
  output logic [2:0]  alu_cs,
  output logic        alu_carry_in,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry_flag,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        zero,
  output logic        carry
);

  // The last cycle of each pass is the cycle in which the alu response is
  // captured.
`ifdef ALU_WAIT_EN
  localparam seq_state_e LOW_LAST  = ST_LOW_W;
  localparam seq_state_e HIGH_LAST = ST_HIGH_W;
`else
  localparam seq_state_e LOW_LAST  = ST_LOW;
  localparam seq_state_e HIGH_LAST = ST_HIGH;
`endif

  seq_state_e  state_r, state_s;
  logic [15:0] a_r, b_r;
  logic [2:0]  cs_r;
  logic        cin_r;
  logic [7:0]  res_lo_r;
  logic        z_lo_r;
  logic        c_lo_r;
  logic [7:0]  drv_a_s, drv_b_s;
  logic [2:0]  drv_cs_s;
  logic        drv_cin_s;
  logic        busy_s;

  // Next-state selection; an unknown encoding falls back to IDLE.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOW;
        else       state_s = ST_IDLE;
      end
`ifdef ALU_WAIT_EN
      ST_LOW:    state_s = ST_LOW_W;
      ST_LOW_W:  state_s = ST_HIGH;
      ST_HIGH:   state_s = ST_HIGH_W;
      ST_HIGH_W: state_s = ST_FIN;
`else
      ST_LOW:    state_s = ST_HIGH;
      ST_HIGH:   state_s = ST_FIN;
`endif
      ST_FIN:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Compute the alu drive for the state being entered.
  // Note: the low pass reads the live request, and the high-pass chain carry
  // reads the live alu response, because both are registered at the same
  // edge.
  always_comb begin
    drv_a_s   = 8'd0;
    drv_b_s   = 8'd0;
    drv_cs_s  = 3'd0;
    drv_cin_s = 1'b0;
    busy_s    = 1'b0;
    case (state_s)
      ST_LOW: begin
        drv_a_s   = op_a[BYTE_W-1:0];
        drv_b_s   = op_b[BYTE_W-1:0];
        drv_cs_s  = op_cs;
        drv_cin_s = op_cin;
        busy_s    = 1'b1;
      end
      ST_HIGH: begin
        drv_a_s   = a_r[2*BYTE_W-1:BYTE_W];
        drv_b_s   = b_r[2*BYTE_W-1:BYTE_W];
        drv_cs_s  = cs_r;
        drv_cin_s = CHAIN_MASK[cs_r] ? alu_carry_flag : cin_r;
        busy_s    = 1'b1;
      end
`ifdef ALU_WAIT_EN
      ST_LOW_W, ST_HIGH_W: begin
        drv_a_s   = alu_dataA;
        drv_b_s   = alu_dataB;
        drv_cs_s  = alu_cs;
        drv_cin_s = alu_carry_in;
        busy_s    = 1'b1;
      end
`endif
      default: begin
        drv_a_s   = 8'd0;
        drv_b_s   = 8'd0;
        drv_cs_s  = 3'd0;
        drv_cin_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
  end

  // State register, request latches, per-pass captures and registered
  // outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      a_r          <= 16'd0;
      b_r          <= 16'd0;
      cs_r         <= 3'd0;
      cin_r        <= 1'b0;
      res_lo_r     <= 8'd0;
      z_lo_r       <= 1'b0;
      c_lo_r       <= 1'b0;
      alu_dataA    <= 8'd0;
      alu_dataB    <= 8'd0;
      alu_cs       <= 3'd0;
      alu_carry_in <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= 16'd0;
      zero         <= 1'b0;
      carry        <= 1'b0;
    end else begin
      state_r      <= state_s;
      alu_dataA    <= drv_a_s;
      alu_dataB    <= drv_b_s;
      alu_cs       <= drv_cs_s;
      alu_carry_in <= drv_cin_s;
      busy         <= busy_s;
      done         <= (state_s == ST_FIN);
      if (state_r == ST_IDLE && start) begin
        a_r   <= op_a;
        b_r   <= op_b;
        cs_r  <= op_cs;
        cin_r <= op_cin;
      end
      if (state_r == LOW_LAST) begin
        res_lo_r <= alu_result;
        z_lo_r   <= alu_zero;
        c_lo_r   <= alu_carry_flag;
      end
      if (state_r == HIGH_LAST) begin
        result <= {alu_result, res_lo_r};
        zero   <= z_lo_r & alu_zero;
        carry  <= alu_carry_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer wired to the 8-bit alu.
// Covers:
//   - the reset state
//   - a table of 16-bit operations, checked cycle by cycle
//   - start held high
//   - reset during HIGH
//   - reset winning over start
module tb_alu16_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] op_a, op_b;
  logic [2:0]  op_cs;
  logic        op_cin;
  logic [7:0]  alu_dataA, alu_dataB, alu_result;
  logic [2:0]  alu_cs;
  logic        alu_carry_in, alu_zero, alu_carry_flag;
  logic        busy, done, zero, carry;
  logic [15:0] result;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [15:0] prev_res;

  always #5 clk = ~clk;

  alu16_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .op_a(op_a), .op_b(op_b), .op_cs(op_cs), .op_cin(op_cin),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_cs(alu_cs),
    .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_carry_flag(alu_carry_flag),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry(carry)
  );

  alu u_alu (
    .dataA(alu_dataA), .dataB(alu_dataB), .cs(alu_cs),
    .carry_in(alu_carry_in),
    .result(alu_result), .zero(alu_zero), .carry_flag(alu_carry_flag)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  cs;
    logic        cin;
    logic        hi_cin;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Check the drive and outputs of a zero-driven, non-busy cycle.
  task automatic chk_quiet(input string tag);
    chk({tag, "_dataA"}, 16'(alu_dataA),    16'h0000);
    chk({tag, "_dataB"}, 16'(alu_dataB),    16'h0000);
    chk({tag, "_cs"},    16'(alu_cs),       16'h0000);
    chk({tag, "_cin"},   16'(alu_carry_in), 16'h0000);
    chk({tag, "_busy"},  16'(busy),         16'h0000);
  endtask

  task automatic run_op(input vec_t v);
    @(negedge clk);
    op_a   = v.a;
    op_b   = v.b;
    op_cs  = v.cs;
    op_cin = v.cin;
    start  = 1'b1;

    // LOW cycle. Scramble the request inputs to prove they were latched.
    @(negedge clk);
    start  = 1'b0;
    op_a   = ~v.a;
    op_b   = ~v.b;
    op_cs  = v.cs ^ 3'b111;
    op_cin = ~v.cin;
    chk("low_dataA", 16'(alu_dataA),    16'(v.a[7:0]));
    chk("low_dataB", 16'(alu_dataB),    16'(v.b[7:0]));
    chk("low_cs",    16'(alu_cs),       16'(v.cs));
    chk("low_cin",   16'(alu_carry_in), 16'(v.cin));
    chk("low_busy",  16'(busy),         16'h0001);
    chk("low_done",  16'(done),         16'h0000);
    chk("low_hold",  result,            prev_res);

    // HIGH cycle.
    @(negedge clk);
    chk("high_dataA", 16'(alu_dataA),    16'(v.a[15:8]));
    chk("high_dataB", 16'(alu_dataB),    16'(v.b[15:8]));
    chk("high_cs",    16'(alu_cs),       16'(v.cs));
    chk("high_cin",   16'(alu_carry_in), 16'(v.hi_cin));
    chk("high_busy",  16'(busy),         16'h0001);
    chk("high_done",  16'(done),         16'h0000);

    // FIN cycle: done asserted in cycle N+3.
    @(negedge clk);
    chk("fin_done",   16'(done),  16'h0001);
    chk("fin_result", result,     v.res);
    chk("fin_zero",   16'(zero),  16'(v.z));
    chk("fin_carry",  16'(carry), 16'(v.c));
    chk_quiet("fin");
    prev_res = v.res;

    // Back in IDLE: done was a single-cycle pulse.
    @(negedge clk);
    chk("idle_done", 16'(done), 16'h0000);
  endtask

  initial begin
    //        a         b         cs      cin   hi_cin  res       z     c
    vecs[0] = '{16'h00FE, 16'h0003, 3'b011, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 3'b011, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{16'h0000, 16'h0000, 3'b011, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vecs[3] = '{16'h00FF, 16'h0001, 3'b000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h5678, 3'b011, 1'b0, 1'b0, 16'h68AC, 1'b0, 1'b0};
    vecs[5] = '{16'hF0F0, 16'h0FF0, 3'b010, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0};
    vecs[6] = '{16'h80FF, 16'h8000, 3'b011, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b1};

    rst      = 1'b1;
    start    = 1'b0;
    op_a     = 16'h0000;
    op_b     = 16'h0000;
    op_cs    = 3'd0;
    op_cin   = 1'b0;
    prev_res = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_done",   16'(done),  16'h0000);
    chk("rst_result", result,     16'h0000);
    chk("rst_zero",   16'(zero),  16'h0000);
    chk("rst_carry",  16'(carry), 16'h0000);
    chk_quiet("rst");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Start held high across edges N..N+6. Accepts at N and N+4;
    // done at cycles N+3 and N+7 only.
    @(negedge clk);
    op_a   = 16'h0001;
    op_b   = 16'h0001;
    op_cs  = 3'b011;
    op_cin = 1'b0;
    start  = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      chk("hold_done", 16'(done), 16'((i == 3) || (i == 7)));
      chk("hold_busy", 16'(busy), 16'((i == 1) || (i == 2) || (i == 5) || (i == 6)));
      if (i == 7) start = 1'b0;
    end
    chk("hold_result", result, 16'h0002);
    prev_res = 16'h0002;

    // Reset asserted during HIGH aborts without a done pulse.
    @(negedge clk);
    op_a   = 16'h80FF;
    op_b   = 16'h8000;
    op_cs  = 3'b011;
    op_cin = 1'b1;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_low_busy", 16'(busy), 16'h0001);
    @(negedge clk);
    chk("abort_high_busy", 16'(busy), 16'h0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_done",   16'(done),  16'h0000);
    chk("abort_result", result,     16'h0000);
    chk("abort_zero",   16'(zero),  16'h0000);
    chk("abort_carry",  16'(carry), 16'h0000);
    chk_quiet("abort");
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", 16'(done), 16'h0000);
    end
    prev_res = 16'h0000;

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_vs_start_busy",  16'(busy),      16'h0000);
    chk("rst_vs_start_dataA", 16'(alu_dataA), 16'h0000);

    // A normal operation completes after the abort.
    run_op(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
